program_counter_ras: RTL and testbench

//   Parametrised program counter for the MIPS core, successor to the 8-bit PC.

---
 rtl/program_counter_ras_if.sv | 30 +++
 rtl/program_counter_ras.sv | 87 ++++++++
 tb/tb_program_counter_ras.sv | 100 ++++++++++
 3 files changed

// File: rtl/program_counter_ras_if.sv
// program_counter_ras_if: flow-control inputs and pc/return-stack status of the program counter
interface program_counter_ras_if #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  logic              stall_i;
  logic              halt_i;
  logic              resume_i;
  logic              jump_i;
  logic              link_i;
  logic              ret_i;
  logic              branch_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] target_i;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] ras_top_o;
  logic [CW-1:0]     ras_count_o;
  logic              ras_overflow_o;
  logic              ras_underflow_o;
  logic              halted_o;
  modport master (
    output stall_i, halt_i, resume_i, jump_i, link_i, ret_i, branch_i, branch_taken_i, target_i,
    input  pc_o, ras_top_o, ras_count_o, ras_overflow_o, ras_underflow_o, halted_o
  );
  modport slave (
    input  stall_i, halt_i, resume_i, jump_i, link_i, ret_i, branch_i, branch_taken_i, target_i,
    output pc_o, ras_top_o, ras_count_o, ras_overflow_o, ras_underflow_o, halted_o
  );
endinterface

// File: rtl/program_counter_ras.sv
// program_counter_ras: fetch-address sequencer with circular return-address stack and halt/resume FSM
module program_counter_ras #(
  parameter int               ADDR_W    = 8,
  parameter int               RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk_i,
  input logic                 reset_ni,
  program_counter_ras_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, HALTED} state_t;
  state_t            state_q;
  logic [1:0]        sync_q;
  logic [ADDR_W-1:0] pc_q, pc_d, top_q, top_d, pc_inc;
  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [PW-1:0]     sp_q, sp_d, sp_m1, sp_m2;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, unf_q, halted_q;
  logic              act, do_push, do_pop, to_target, empty, full;
  // sync_q[1] releases the core only after reset deassertion has passed two clock edges
  assign act       = sync_q[1] & (state_q == RUN) & ~bus.halt_i & ~bus.stall_i;
  assign do_pop    = act & bus.ret_i;
  assign do_push   = act & ~bus.ret_i & bus.jump_i & bus.link_i;
  assign to_target = act & ~bus.ret_i & (bus.jump_i | (bus.branch_i & bus.branch_taken_i));
  assign empty     = cnt_q == '0;
  assign full      = cnt_q == CW'(RAS_DEPTH);
  assign pc_inc    = pc_q + 1'b1;
  assign sp_m1     = sp_q - 1'b1;
  assign sp_m2     = sp_q - PW'(2);
  always_comb begin
    pc_d  = do_pop && !empty ? stack_q[sp_m1] : to_target ? bus.target_i : act ? pc_inc : pc_q;
    sp_d  = do_pop && !empty ? sp_m1 : do_push ? sp_q + 1'b1 : sp_q;
    cnt_d = do_pop && !empty ? cnt_q - 1'b1 : do_push && !full ? cnt_q + 1'b1 : cnt_q;
    top_d = do_pop ? (cnt_q > CW'(1) ? stack_q[sp_m2] : '0) : do_push ? pc_inc : top_q;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q   <= '0;
      state_q  <= RUN;
      halted_q <= 1'b0;
      pc_q     <= RESET_PC;
      sp_q     <= '0;
      cnt_q    <= '0;
      top_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      if (sync_q[1]) begin
        if (state_q == HALTED) begin
          if (bus.resume_i) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
            sp_q     <= '0;
            cnt_q    <= '0;
            top_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
          end
        end else if (bus.halt_i) begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end else begin
          pc_q  <= pc_d;
          sp_q  <= sp_d;
          cnt_q <= cnt_d;
          top_q <= top_d;
          ovf_q <= ovf_q | (do_push & full);
          unf_q <= unf_q | (do_pop & empty);
        end
      end
    end
  end
  // Storage needs no reset: entries are only read while cnt_q says they were written
  always_ff @(posedge clk_i) begin
    if (do_push) stack_q[sp_q] <= pc_inc;
  end
  assign bus.pc_o            = pc_q;
  assign bus.ras_top_o       = top_q;
  assign bus.ras_count_o     = cnt_q;
  assign bus.ras_overflow_o  = ovf_q;
  assign bus.ras_underflow_o = unf_q;
  assign bus.halted_o        = halted_q;
endmodule

// File: tb/tb_program_counter_ras.sv
// tb_program_counter_ras: directed scoreboard bench for program_counter_ras
module tb_program_counter_ras;
  localparam logic [7:0] ST = 8'h01, HL = 8'h02, RS = 8'h04, JP = 8'h08,
                         LK = 8'h10, RT = 8'h20, BR = 8'h40, TK = 8'h80;
  typedef struct {
    logic [7:0] pc;
    logic [7:0] top;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
    logic       hlt;
  } exp_t;
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t  exp_q [$];
  string tag_q [$];
  program_counter_ras_if #(.ADDR_W(8), .RAS_DEPTH(4)) bus ();
  program_counter_ras #(.ADDR_W(8), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic exp_t e(input logic [7:0] pc, top, input logic [2:0] cnt, input logic ovf, unf, hlt);
    exp_t x;
    x.pc = pc; x.top = top; x.cnt = cnt; x.ovf = ovf; x.unf = unf; x.hlt = hlt;
    return x;
  endfunction
  task automatic drive(input logic [7:0] ctl, input logic [7:0] tg);
    bus.stall_i = ctl[0]; bus.halt_i = ctl[1]; bus.resume_i = ctl[2]; bus.jump_i = ctl[3];
    bus.link_i = ctl[4]; bus.ret_i = ctl[5]; bus.branch_i = ctl[6]; bus.branch_taken_i = ctl[7];
    bus.target_i = tg;
  endtask
  task automatic cmp(input string tag, input exp_t x);
    tests++;
    assert (bus.pc_o === x.pc) else begin fails++; $error("FAIL %s pc got %0h exp %0h", tag, bus.pc_o, x.pc); end
    tests++;
    assert (bus.ras_top_o === x.top) else begin fails++; $error("FAIL %s ras_top got %0h exp %0h", tag, bus.ras_top_o, x.top); end
    tests++;
    assert (bus.ras_count_o === x.cnt) else begin fails++; $error("FAIL %s ras_count got %0d exp %0d", tag, bus.ras_count_o, x.cnt); end
    tests++;
    assert ({bus.ras_overflow_o, bus.ras_underflow_o, bus.halted_o} === {x.ovf, x.unf, x.hlt}) else begin
      fails++;
      $error("FAIL %s ovf/unf/halted got %b%b%b exp %b%b%b", tag, bus.ras_overflow_o, bus.ras_underflow_o, bus.halted_o, x.ovf, x.unf, x.hlt);
    end
  endtask
  task automatic step(input string tag, input logic [7:0] ctl, input logic [7:0] tg, input exp_t x);
    drive(ctl, tg);
    exp_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    cmp(tag_q.pop_front(), exp_q.pop_front());
  endtask
  initial begin
    drive(8'h00, 8'h00);
    #12;
    cmp("reset", e(8'h00, 8'h00, 0, 0, 0, 0));
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) step("sync", ST, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0));
    for (int i = 1; i <= 5; i++) step("incr", 8'h00, 8'h00, e(8'(i), 8'h00, 0, 0, 0, 0));
    step("jmp_ff", JP, 8'hFF, e(8'hFF, 8'h00, 0, 0, 0, 0));
    step("wrap", 8'h00, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0));
    step("link_only", LK, 8'h77, e(8'h01, 8'h00, 0, 0, 0, 0));
    step("jmp10", JP, 8'd10, e(8'd10, 8'h00, 0, 0, 0, 0));
    step("call40", JP | LK, 8'd40, e(8'd40, 8'd11, 1, 0, 0, 0));
    step("ret11", RT, 8'h00, e(8'd11, 8'h00, 0, 0, 0, 0));
    step("jmp1", JP, 8'd1, e(8'd1, 8'h00, 0, 0, 0, 0));
    for (int i = 2; i <= 5; i++) step("nest", JP | LK, 8'(i), e(8'(i), 8'(i), 3'(i - 1), 0, 0, 0));
    step("nest_ovf", JP | LK, 8'd6, e(8'd6, 8'd6, 4, 1, 0, 0));
    step("pop1", RT, 8'h00, e(8'd6, 8'd5, 3, 1, 0, 0));
    step("pop2", RT, 8'h00, e(8'd5, 8'd4, 2, 1, 0, 0));
    step("pop3", RT, 8'h00, e(8'd4, 8'd3, 1, 1, 0, 0));
    step("pop4", RT, 8'h00, e(8'd3, 8'h00, 0, 1, 0, 0));
    step("pop_unf", RT, 8'h00, e(8'd4, 8'h00, 0, 1, 1, 0));
    step("jmp20", JP, 8'd20, e(8'd20, 8'h00, 0, 1, 1, 0));
    step("br_nt", BR, 8'd7, e(8'd21, 8'h00, 0, 1, 1, 0));
    step("br_t", BR | TK, 8'd7, e(8'd7, 8'h00, 0, 1, 1, 0));
    step("stall_jmp", ST | JP | LK, 8'd50, e(8'd7, 8'h00, 0, 1, 1, 0));
    step("jmp30", JP, 8'd30, e(8'd30, 8'h00, 0, 1, 1, 0));
    step("halt", HL | JP, 8'd50, e(8'd30, 8'h00, 0, 1, 1, 1));
    for (int i = 0; i < 10; i++) step("halted", (i % 2) ? (JP | LK) : (RT | BR | TK), 8'd50, e(8'd30, 8'h00, 0, 1, 1, 1));
    step("resume", RS, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0));
    step("run_again", 8'h00, 8'h00, e(8'h01, 8'h00, 0, 0, 0, 0));
    step("call_pre", JP | LK, 8'd40, e(8'd40, 8'd2, 1, 0, 0, 0));
    drive(JP | LK, 8'd90);
    #3;
    reset_ni = 1'b0;
    #1;
    cmp("async_rst", e(8'h00, 8'h00, 0, 0, 0, 0));
    #1;
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) step("resync", ST, 8'h00, e(8'h00, 8'h00, 0, 0, 0, 0));
    step("call_b", JP | LK, 8'd40, e(8'd40, 8'd1, 1, 0, 0, 0));
    step("ret_jl", RT | JP | LK, 8'd90, e(8'd1, 8'h00, 0, 0, 0, 0));
    step("no_push", 8'h00, 8'h00, e(8'd2, 8'h00, 0, 0, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
